// File: rtl/jk_updown_counter.sv
// Mod-MODULUS up/down counter built from per-bit JK cells driven by toggle/hold excitation.
// Latency: one cycle, inputs sampled at posedge give the new q after that edge; jk_j/jk_k/tc are combinational.
// Backpressure: none, the counter accepts load/en on every cycle and never stalls.
module jk_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             tc,
  output logic             err
);

  // Highest legal count; the extended modulus lets MODULUS == 2**WIDTH compare correctly.
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] q_jk;
  logic             clip;
  logic             din_ok;

  assign din_ok = ({1'b0, din} < MOD_EXT);

  // Target next count by priority: load, count up, count down, hold.
  // Any corrupted state above LAST is steered back into the legal range.
  always_comb begin
    nxt  = q;
    clip = 1'b0;
    if (load) begin
      if (din_ok) begin
        nxt = din;
      end else begin
        nxt  = '0;
        clip = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (q >= LAST) nxt = '0;
        else           nxt = q + 1'b1;
      end else begin
        if ((q == '0) || (q > LAST)) nxt = LAST;
        else                         nxt = q - 1'b1;
      end
    end
  end

  // Excitation: a bit that must change gets (1,1) toggle, otherwise (0,0) hold.
  assign jk_j = q ^ nxt;
  assign jk_k = q ^ nxt;

  // JK characteristic equation per bit; this is what the flops actually capture.
  assign q_jk = (jk_j & ~q) | (~jk_k & q);

  assign q_bar = ~q;

  assign tc = en & ~load & ((up & (q == LAST)) | (~up & (q == '0)));

  // Count state register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= q_jk;
  end

  // Sticky illegal-load flag; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    err <= 1'b0;
    else if (clip) err <= 1'b1;
  end

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed bench for jk_updown_counter: MODULUS=10 main instance plus a full-range MODULUS=16 instance.
// Latency: each step drives inputs 1 time unit after posedge and checks after the next posedge.
// Backpressure: not applicable.
module tb_jk_updown_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] din;

  logic [3:0] q, q_bar, jk_j, jk_k;
  logic       tc, err;

  logic [3:0] q16, q_bar16, jk_j16, jk_k16;
  logic       tc16, err16;

  int checks   = 0;
  int failures = 0;

  jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .din(din),
    .q(q), .q_bar(q_bar), .jk_j(jk_j), .jk_k(jk_k), .tc(tc), .err(err)
  );

  jk_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .din(din),
    .q(q16), .q_bar(q_bar16), .jk_j(jk_j16), .jk_k(jk_k16), .tc(tc16), .err(err16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cur;
    int nxt;

    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b0;
    #1;
    chk("rst_q", q, 0);
    chk("rst_qbar", q_bar, 4'hF);
    chk("rst_err", err, 0);

    // Edges with reset held low must not count.
    en = 1'b1; up = 1'b1;
    step();
    step();
    chk("rst_hold_q", q, 0);
    reset = 1'b1;

    // Count up 12 edges from 0 with wrap at 9.
    cur = 0;
    for (int i = 0; i < 12; i++) begin
      chk("up_tc", tc, (cur == 9) ? 1 : 0);
      if (cur == 9) begin
        chk("up_j9", jk_j, 4'b1001);
        chk("up_k9", jk_k, 4'b1001);
      end
      step();
      cur = (cur == 9) ? 0 : cur + 1;
      chk("up_q", q, cur);
    end

    // Count down from 2 through the 0 -> 9 wrap to 8.
    up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("dn_tc", tc, (cur == 0) ? 1 : 0);
      if (cur == 0) begin
        chk("dn_j0", jk_j, 4'b1001);
        chk("dn_k0", jk_k, 4'b1001);
      end
      step();
      nxt = (cur == 0) ? 9 : cur - 1;
      cur = nxt;
      chk("dn_q", q, cur);
    end

    // Load beats enable.
    load = 1'b1; din = 4'd7; up = 1'b1;
    step();
    chk("ld7_q", q, 7);
    din = 4'd9;
    step();
    chk("ld9_q", q, 9);
    chk("ld_err0", err, 0);
    din = 4'd12;
    #1;
    chk("ld_tc0", tc, 0);
    step();
    chk("ld12_q", q, 0);
    chk("ld12_err", err, 1);
    din = 4'd3;
    step();
    chk("ld3_q", q, 3);
    chk("ld3_err", err, 1);

    // Hold at 5.
    din = 4'd5;
    step();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_q", q, 5);
      chk("hold_j", jk_j, 0);
      chk("hold_k", jk_k, 0);
      chk("hold_tc", tc, 0);
    end

    // Direction change mid-count: 6, 7, then 6, 5.
    en = 1'b1; up = 1'b1;
    step(); chk("dir_q6", q, 6);
    step(); chk("dir_q7", q, 7);
    up = 1'b0;
    step(); chk("dir_q6b", q, 6);
    step(); chk("dir_q5", q, 5);

    // Reset between edges at q=6.
    up = 1'b1;
    step(); chk("pre_rst_q", q, 6);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_q", q, 0);
    chk("mid_rst_qbar", q_bar, 4'hF);
    chk("mid_rst_err", err, 0);
    step();
    reset = 1'b1;

    // Full-range modulus: 15 -> 0 going up, 0 -> 15 going down.
    load = 1'b1; din = 4'd15; en = 1'b0;
    step();
    chk("m16_ld_q", q16, 15);
    chk("m10_ld15_q", q, 0);
    chk("m10_ld15_err", err, 1);
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    chk("m16_tc_up", tc16, 1);
    step();
    chk("m16_up_q", q16, 0);
    up = 1'b0;
    #1;
    chk("m16_tc_dn", tc16, 1);
    step();
    chk("m16_dn_q", q16, 15);
    chk("m16_err", err16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_updown_counter.md
# jk_updown_counter

Synchronous mod-N up/down counter whose state bits are JK flip-flop cells. Each cycle it computes the next count, derives the J/K excitation per bit, and applies the JK characteristic equation. It sits directly downstream of the single jk_ff cell and is the first multi-bit consumer of that cell behaviour. It also exports its J/K vectors so benches can check the excitation against the JK truth table.

## Interface
Parameters:
- WIDTH, 4, number of JK state bits.
- MODULUS, 10, count range 0..MODULUS-1; legal range 2 ≤ MODULUS ≤ 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; one clock domain only.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load; priority over en.
- din  input  WIDTH  load value.
- q  output  WIDTH  registered count.
- q_bar  output  WIDTH  bitwise complement of q, always ~q.
- jk_j  output  WIDTH  J excitation applied at the next edge (combinational).
- jk_k  output  WIDTH  K excitation applied at the next edge (combinational).
- tc  output  1  terminal count (combinational).
- err  output  1  sticky illegal-load flag (registered).

## Operation
Target next value n, by priority:
1. load=1: n = din if din < MODULUS, else n = 0 and err set.
2. en=1, up=1: n = q+1, except q = MODULUS-1 wraps to n = 0.
3. en=1, up=0: n = q-1, except q = 0 wraps to n = MODULUS-1.
4. Otherwise: n = q (hold).

Excitation and update:
- Per bit, t_i = q_i ^ n_i, and jk_j[i] = jk_k[i] = t_i. Only toggle (1,1) and hold (0,0) are used.
- Each bit updates by the JK equation: q_i ← (j_i & ~q_i) | (~k_i & q_i). This must equal n for every legal case.

Outputs:
- tc = en & ~load & ((up & q == MODULUS-1) | (~up & q == 0)).
- err sets on a clipped load and holds until reset. A legal load does not clear it.
- State q ≥ MODULUS is reachable only if MODULUS < 2**WIDTH and state is corrupted. In that case, count up → 0 and count down → MODULUS-1.

## Timing
- Reset asserted (reset=0): immediately q=0, q_bar=all ones, err=0, independent of clk. Then jk_j/jk_k/tc follow from q=0 and the current inputs.
- Reset release is sampled at the next rising clk edge; no counting on the edge where reset is still low.
- Latency: load, en, up and din sampled at posedge t give new q at posedge t, visible after the edge. One-cycle registered path.
- jk_j, jk_k and tc are combinational from q and the inputs; they settle within the same cycle.
- load and en together: load wins, and tc=0.
- Direction change mid-count takes effect on the same edge it is sampled.
- Reset mid-count clears asynchronously; no partial update completes.

## Test plan
Use WIDTH=4, MODULUS=10 unless noted.
- **Reset:** pulse reset=0 mid-cycle → q=0, q_bar=4'b1111, err=0 without waiting for clk; with reset held low, edges leave q=0.
- **Up wrap:** en=1, up=1 for 12 edges from 0 → q steps 1..9, 0, 1, 2. tc=1 only while q=9. At q=9, jk_j = jk_k = 4'b1001.
- **Down wrap:** en=1, up=0 from q=0 → q=9, 8, 7…. tc=1 while q=0. At q=0, jk_j = jk_k = 4'b1001.
- **Load priority:** load=1, en=1, din=7 → q=7 next edge, tc=0. Then load=1, din=12 → q=0, err=1. Then a legal load din=3 → q=3, err stays 1.
- **Hold:** en=0, load=0 for 5 edges at q=5 → q stays 5, jk_j = jk_k = 0, tc=0. Toggle up mid-count at q=5 → sequence 6, 7, 6, 5.
- **Edge cases:** MODULUS=16 → up from 15 wraps to 0 and down from 0 goes to 15. Separately, assert reset at q=6 between edges → q=0 at once.
